// File: rtl/shift_sequencer.sv
// shift_sequencer
// ----------------
// Command sequencer for an 8-bit bidirectional shift register. One job is
// accepted per cmd handshake: a value to load, a direction, and a number of
// shift steps. The sequencer loads the register and applies the shifts. It then
// samples the register output and returns the result on a valid/ready
// response channel. The shift register itself stays a plain slave.
//
// Ports
//   clock, reset        rising-edge clock; asynchronous active-high reset
//   cmd_valid/ready     command handshake (ready only in IDLE)
//   cmd_data/left/count job payload, latched at the accept edge
//   sr_enable/load/shiftLeft/datain  drive the shift register
//   sr_dataout          shift register output, sampled in CAPTURE
//   rsp_valid/ready     response handshake
//   rsp_data            shifted result, held until the response handshake
//   busy                high whenever a job is in flight (state != IDLE)
//
// Timing: accept edge E0 -> LOAD -> count x SHIFT -> CAPTURE -> RESP.
// rsp_valid first goes high in the cycle after edge E0+count+2.
module shift_sequencer #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic             cmd_left,
    input  logic [CNT_W-1:0] cmd_count,
    output logic             sr_enable,
    output logic             sr_load,
    output logic             sr_shiftLeft,
    output logic [WIDTH-1:0] sr_datain,
    input  logic [WIDTH-1:0] sr_dataout,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             busy
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        SHIFT   = 3'd2,
        CAPTURE = 3'd3,
        RESP    = 3'd4
    } state_t;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             left;
        logic [CNT_W-1:0] count;
    } job_t;

    state_t           state;
    state_t           state_nxt;
    job_t             job;
    logic [CNT_W-1:0] cnt;
    logic             accept;

    // cmd_ready is decoded from state alone, so accept never feeds back
    // combinationally into anything visible on the command port.
    assign accept = cmd_valid && (state == IDLE);

    // ---------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) state_nxt = LOAD;
            end
            LOAD: begin
                // A zero-step job skips SHIFT entirely, which also keeps the
                // down-counter from ever being entered at zero.
                if (job.count == '0) state_nxt = CAPTURE;
                else                 state_nxt = SHIFT;
            end
            SHIFT: begin
                if (cnt == CNT_W'(1)) state_nxt = CAPTURE;
            end
            CAPTURE: begin
                state_nxt = RESP;
            end
            RESP: begin
                if (rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------------------------------------------------------
    // Job latch, shift counter and result register
    // ---------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            job      <= '0;
            cnt      <= '0;
            rsp_data <= '0;
        end else begin
            if (accept) begin
                job.data  <= cmd_data;
                job.left  <= cmd_left;
                job.count <= cmd_count;
            end
            if (state == LOAD) begin
                cnt <= job.count;
            end else if (state == SHIFT) begin
                cnt <= cnt - 1'b1;
            end
            // The register holds its final value through CAPTURE, because
            // enable is low there. Sample it at the closing edge.
            if (state == CAPTURE) begin
                rsp_data <= sr_dataout;
            end
        end
    end

    // ---------------------------------------------------------------
    // Outputs, decoded purely from registered state
    // ---------------------------------------------------------------
    always_comb begin
        cmd_ready    = 1'b0;
        sr_enable    = 1'b0;
        sr_load      = 1'b0;
        sr_shiftLeft = 1'b0;
        sr_datain    = '0;
        rsp_valid    = 1'b0;
        busy         = 1'b1;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
            end
            LOAD: begin
                sr_enable    = 1'b1;
                sr_load      = 1'b1;
                sr_shiftLeft = job.left;
                sr_datain    = job.data;
            end
            SHIFT: begin
                // datain is held during shifting so the register inputs
                // change only at job boundaries.
                sr_enable    = 1'b1;
                sr_shiftLeft = job.left;
                sr_datain    = job.data;
            end
            CAPTURE: begin
            end
            RESP: begin
                rsp_valid = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_shift_sequencer.sv
module tb_shift_sequencer;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic             clock;
    logic             reset;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [WIDTH-1:0] cmd_data;
    logic             cmd_left;
    logic [CNT_W-1:0] cmd_count;
    logic             sr_enable;
    logic             sr_load;
    logic             sr_shiftLeft;
    logic [WIDTH-1:0] sr_datain;
    logic [WIDTH-1:0] sr_dataout;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             busy;

    int  total  = 0;
    int  passed = 0;
    time t_accept;

    shift_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clock        (clock),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_data     (cmd_data),
        .cmd_left     (cmd_left),
        .cmd_count    (cmd_count),
        .sr_enable    (sr_enable),
        .sr_load      (sr_load),
        .sr_shiftLeft (sr_shiftLeft),
        .sr_datain    (sr_datain),
        .sr_dataout   (sr_dataout),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .busy         (busy)
    );

    // Downstream shift register (plain slave, logical shifts with zero fill)
    logic [WIDTH-1:0] sr_q = '0;
    always_ff @(posedge clock) begin
        if (sr_enable) begin
            if (sr_load)           sr_q <= sr_datain;
            else if (sr_shiftLeft) sr_q <= sr_q << 1;
            else                   sr_q <= sr_q >> 1;
        end
    end
    assign sr_dataout = sr_q;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Watchdog
    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Reference: the whole job is one logical shift by count
    function automatic logic [WIDTH-1:0] ref_shift(input logic [WIDTH-1:0] d,
                                                   input logic l, input int c);
        if (c >= WIDTH) return '0;
        return l ? (d << c) : (d >> c);
    endfunction

    // Runs one job starting at a negedge with the sequencer in IDLE.
    // stall = number of extra RESP cycles with rsp_ready low (0 = ready held high).
    // nv/nd/nl/nc = command presented by the producer while stalled.
    task automatic run_job(input logic [WIDTH-1:0] d, input logic l, input logic [CNT_W-1:0] c,
                           input int stall, input logic nv, input logic [WIDTH-1:0] nd,
                           input logic nl, input logic [CNT_W-1:0] nc);
        logic [WIDTH-1:0] exp;
        int en_cnt, ld_cnt, bad_ctl, bad_stall, first_rv;
        logic ld_first;
        exp = ref_shift(d, l, int'(c));
        en_cnt = 0; ld_cnt = 0; bad_ctl = 0; bad_stall = 0; first_rv = 0; ld_first = 0;

        total++;
        if (cmd_ready !== 1'b1) $display("FAIL cmd_ready_before_job: got %b want 1", cmd_ready);
        else passed++;

        cmd_valid = 1'b1; cmd_data = d; cmd_left = l; cmd_count = c;
        rsp_ready = (stall == 0);
        @(posedge clock);
        t_accept = $time;
        for (int k = 1; k <= 40 && first_rv == 0; k++) begin
            @(negedge clock);
            if (k == 1) cmd_valid = 1'b0;
            if (rsp_valid === 1'b1) begin
                first_rv = k;
            end else begin
                if (sr_enable === 1'b1) en_cnt++;
                if (sr_load === 1'b1) begin
                    ld_cnt++;
                    if (k == 1) ld_first = 1'b1;
                end
                if (sr_enable === 1'b1 && (sr_shiftLeft !== l || sr_datain !== d)) bad_ctl++;
                if (cmd_ready !== 1'b0 || busy !== 1'b1) bad_ctl++;
            end
        end

        total++;
        if (first_rv != int'(c) + 3) $display("FAIL latency: got %0d want %0d (count %0d)", first_rv, int'(c) + 3, c);
        else passed++;
        if (first_rv == 0) return;

        total++;
        if (en_cnt != int'(c) + 1) $display("FAIL enable_cycles: got %0d want %0d", en_cnt, int'(c) + 1);
        else passed++;
        total++;
        if (ld_cnt != 1 || !ld_first) $display("FAIL load_pulse: got %0d pulses first=%b want 1 in first cycle", ld_cnt, ld_first);
        else passed++;
        total++;
        if (bad_ctl != 0) $display("FAIL sr_ctl_busy: got %0d bad cycles want 0", bad_ctl);
        else passed++;
        total++;
        if (rsp_data !== exp) $display("FAIL rsp_data: got %0h want %0h (d %0h l %b c %0d)", rsp_data, exp, d, l, c);
        else passed++;

        for (int s = 0; s < stall; s++) begin
            if (nv) begin
                cmd_valid = 1'b1; cmd_data = nd; cmd_left = nl; cmd_count = nc;
            end
            @(negedge clock);
            if (rsp_valid !== 1'b1 || rsp_data !== exp || cmd_ready !== 1'b0 || sr_enable !== 1'b0) bad_stall++;
        end
        if (stall > 0) begin
            total++;
            if (bad_stall != 0) $display("FAIL resp_stall: got %0d bad cycles want 0", bad_stall);
            else passed++;
        end

        rsp_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        rsp_ready = 1'b0;
        total++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0 || sr_enable !== 1'b0)
            $display("FAIL post_handshake_idle: got valid %b ready %b busy %b en %b want 0 1 0 0",
                     rsp_valid, cmd_ready, busy, sr_enable);
        else passed++;
    endtask

    task automatic test_reset();
        reset = 1'b1; cmd_valid = 1'b0; cmd_data = '0; cmd_left = 1'b0; cmd_count = '0; rsp_ready = 1'b0;
        repeat (2) @(negedge clock);
        total++;
        if (cmd_ready !== 1'b1 || sr_enable !== 1'b0 || sr_load !== 1'b0 || sr_shiftLeft !== 1'b0 ||
            sr_datain !== '0 || rsp_valid !== 1'b0 || rsp_data !== '0 || busy !== 1'b0)
            $display("FAIL reset_values: got rdy %b en %b ld %b sl %b din %0h rv %b rd %0h busy %b",
                     cmd_ready, sr_enable, sr_load, sr_shiftLeft, sr_datain, rsp_valid, rsp_data, busy);
        else passed++;
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_basic();
        run_job(8'hA5, 1'b1, 4'd1, 0, 1'b0, '0, 1'b0, '0);
        run_job(8'h81, 1'b0, 4'd3, 0, 1'b0, '0, 1'b0, '0);
        run_job(8'h3C, 1'b1, 4'd0, 0, 1'b0, '0, 1'b0, '0);
    endtask

    task automatic test_back_to_back();
        time t0;
        run_job(8'hFF, 1'b1, 4'd9, 0, 1'b0, '0, 1'b0, '0);
        t0 = t_accept;
        run_job(8'h01, 1'b1, 4'd7, 0, 1'b0, '0, 1'b0, '0);
        total++;
        if (t_accept - t0 != 130) $display("FAIL throughput: got %0t want 130 between accepts", t_accept - t0);
        else passed++;
    endtask

    task automatic test_stall();
        run_job(8'hC3, 1'b0, 4'd2, 5, 1'b1, 8'h96, 1'b1, 4'd2);
        // pending command is still asserted; it is accepted after the IDLE cycle
        run_job(8'h96, 1'b1, 4'd2, 0, 1'b0, '0, 1'b0, '0);
    endtask

    task automatic test_reset_mid_job();
        int bad;
        bad = 0;
        cmd_valid = 1'b1; cmd_data = 8'h5A; cmd_left = 1'b1; cmd_count = 4'd5; rsp_ready = 1'b1;
        @(posedge clock);
        @(negedge clock); cmd_valid = 1'b0;   // LOAD
        @(negedge clock);                     // SHIFT 1
        @(negedge clock);                     // SHIFT 2
        total++;
        if (sr_enable !== 1'b1 || sr_load !== 1'b0) $display("FAIL mid_shift: got en %b ld %b want 1 0", sr_enable, sr_load);
        else passed++;
        reset = 1'b1;
        #1;
        total++;
        if (cmd_ready !== 1'b1 || sr_enable !== 1'b0 || sr_load !== 1'b0 || sr_shiftLeft !== 1'b0 ||
            sr_datain !== '0 || rsp_valid !== 1'b0 || rsp_data !== '0 || busy !== 1'b0)
            $display("FAIL async_reset: got rdy %b en %b ld %b sl %b din %0h rv %b rd %0h busy %b",
                     cmd_ready, sr_enable, sr_load, sr_shiftLeft, sr_datain, rsp_valid, rsp_data, busy);
        else passed++;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            if (rsp_valid !== 1'b0 || sr_enable !== 1'b0 || cmd_ready !== 1'b1) bad++;
        end
        total++;
        if (bad != 0) $display("FAIL aborted_job_quiet: got %0d bad cycles want 0", bad);
        else passed++;
        run_job(8'h5A, 1'b1, 4'd5, 0, 1'b0, '0, 1'b0, '0);
    endtask

    task automatic test_random();
        for (int j = 0; j < 25; j++) begin
            logic [WIDTH-1:0] d;
            logic l;
            logic [CNT_W-1:0] c;
            d = WIDTH'($urandom);
            l = 1'($urandom);
            c = CNT_W'($urandom_range(0, 15));
            run_job(d, l, c, int'($urandom_range(0, 3)), 1'b0, '0, 1'b0, '0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_stall();
        test_reset_mid_job();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
